// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART transmit arbiter:
//                arbiter FSM state encoding and default payload width.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Default byte width shared by requesters and the transmitter.
    localparam int c_payload_bits_default = 8;

    // Arbiter FSM states, explicitly encoded.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_NEXT = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_select.sv
`default_nettype none
// ============================================================================
//  Module      : rr_select
//  Description : Combinational round-robin pick. Returns the one-hot position
//                of the first active request at or after the pointer,
//                wrapping from the top index back to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_select #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_pick
);

    logic w_found;

    // Scan offsets 0..N_REQ-1 from the pointer; the first active request wins.
    always_comb begin
        o_pick  = '0;
        w_found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!w_found && (i == ((int'(i_ptr) + k) % N_REQ)) && i_req[i]) begin
                    o_pick[i] = 1'b1;
                    w_found   = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Shares one UART transmitter between N_REQ message sources.
//                Ownership is granted round-robin and held for a whole
//                message; over-long messages are force-released with a
//                one-cycle error pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int PAYLOAD_BITS  = c_payload_bits_default,
    parameter int MAX_MSG_BYTES = 32
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*PAYLOAD_BITS-1:0] req_data,
    input  logic [N_REQ-1:0]              req_last,
    output logic [N_REQ-1:0]              req_ready,
    output logic [N_REQ-1:0]              grant,
    output logic                          uart_tx_en,
    output logic [PAYLOAD_BITS-1:0]       uart_tx_data,
    input  logic                          uart_tx_busy,
    output logic                          err_overlong
);

    localparam int                c_ptr_w   = $clog2(N_REQ);
    localparam int                c_cnt_w   = $clog2(MAX_MSG_BYTES + 1);
    localparam logic [c_cnt_w-1:0] c_max_cnt = c_cnt_w'(MAX_MSG_BYTES);
    localparam logic [c_ptr_w-1:0] c_last_idx = c_ptr_w'(N_REQ - 1);

    arb_state_t              r_state,      w_state_nxt;
    logic [N_REQ-1:0]        r_grant,      w_grant_nxt;
    logic [c_ptr_w-1:0]      r_rr_ptr,     w_rr_ptr_nxt;
    logic [c_cnt_w-1:0]      r_byte_cnt,   w_byte_cnt_nxt;
    logic                    r_last,       w_last_nxt;
    logic                    r_wait_first, w_wait_first_nxt;

    logic [N_REQ-1:0]        w_pick;
    logic [c_ptr_w-1:0]      w_gidx;
    logic [PAYLOAD_BITS-1:0] w_gdata;
    logic                    w_gvalid;
    logic                    w_glast;
    logic                    w_send;
    logic                    w_overlong;
    logic                    w_send_ok;

    rr_select #(
        .N_REQ (N_REQ),
        .PTR_W (c_ptr_w)
    ) u_rr_select (
        .i_req  (req_valid),
        .i_ptr  (r_rr_ptr),
        .o_pick (w_pick)
    );

    // Owner's index and byte, selected through the one-hot grant.
    always_comb begin
        w_gidx  = '0;
        w_gdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant[i]) begin
                w_gidx  = c_ptr_w'(i);
                w_gdata = req_data[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end
    end

    assign w_gvalid = |(req_valid & r_grant);
    assign w_glast  = |(req_last & r_grant);

    // Next-state and strobe decode; every next value defaults to hold.
    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_rr_ptr_nxt     = r_rr_ptr;
        w_byte_cnt_nxt   = r_byte_cnt;
        w_last_nxt       = r_last;
        w_wait_first_nxt = r_wait_first;
        w_send           = 1'b0;
        w_overlong       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|req_valid) begin
                    w_grant_nxt    = w_pick;
                    w_byte_cnt_nxt = '0;
                    w_last_nxt     = 1'b0;
                    w_state_nxt    = ST_SEND;
                end
            end
            ST_SEND: begin
                // A stalled owner keeps the grant; we simply wait here.
                if (!uart_tx_busy && w_gvalid) begin
                    w_send           = 1'b1;
                    w_byte_cnt_nxt   = r_byte_cnt + c_cnt_w'(1);
                    w_last_nxt       = w_glast;
                    w_wait_first_nxt = 1'b1;
                    w_state_nxt      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Busy may not have risen yet in the first cycle after the strobe.
                if (r_wait_first) begin
                    w_wait_first_nxt = 1'b0;
                end else if (!uart_tx_busy) begin
                    w_state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (r_last || (r_byte_cnt == c_max_cnt)) begin
                    w_overlong   = !r_last;
                    w_rr_ptr_nxt = (w_gidx == c_last_idx) ? '0 : w_gidx + c_ptr_w'(1);
                    w_grant_nxt  = '0;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_state_nxt = ST_SEND;
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and bookkeeping registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_rr_ptr     <= '0;
            r_byte_cnt   <= '0;
            r_last       <= 1'b0;
            r_wait_first <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_last       <= w_last_nxt;
            r_wait_first <= w_wait_first_nxt;
        end
    end

    // Strobes are suppressed while reset is asserted so an abandoned message
    // cannot emit one more byte in the reset cycle.
    assign w_send_ok    = w_send & resetn;
    assign uart_tx_en   = w_send_ok;
    assign req_ready    = w_send_ok ? r_grant : '0;
    assign uart_tx_data = w_send_ok ? w_gdata : '0;
    assign err_overlong = w_overlong & resetn;
    assign grant        = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Self-checking bench for uart_tx_arbiter. Requesters are
//                message queues, the transmitter is a busy-counter model and
//                an event-level reference tracks ownership, byte order,
//                release and overlong pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N    = 4;
    localparam int PB   = 8;
    localparam int MAXB = 4;
    localparam int DW   = N * PB;

    logic          clk = 1'b0;
    logic          resetn;
    logic [N-1:0]  req_valid;
    logic [DW-1:0] req_data;
    logic [N-1:0]  req_last;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  grant;
    logic          uart_tx_en;
    logic [PB-1:0] uart_tx_data;
    logic          uart_tx_busy;
    logic          err_overlong;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ         (N),
        .PAYLOAD_BITS  (PB),
        .MAX_MSG_BYTES (MAXB)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .grant        (grant),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_data (uart_tx_data),
        .uart_tx_busy (uart_tx_busy),
        .err_overlong (err_overlong)
    );

    int total = 0;
    int bad   = 0;

    // Requester side: pending bytes per source.
    logic [PB-1:0] q_data [N][$];
    logic          q_last [N][$];
    logic          stall  [N];
    int            pushed_bytes;

    // Transmitter model.
    int busy_cnt;
    int busy_len;

    // Reference model state.
    int   m_ptr, m_owner, m_next_owner, m_cnt;
    logic m_fin, m_expect_ovl, m_ovl_seen;
    int   ovl_count;
    int   grant_log [$];
    int   sent_owner [$];
    logic [PB-1:0] sent_data [$];

    function automatic logic [N-1:0] onehot(input int idx);
        logic [N-1:0] r;
        r = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

    // Arbitration rule: lowest index at or after the pointer, wrapping.
    function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic pending();
        for (int i = 0; i < N; i++) if (q_data[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < N; i++) begin
            q_data[i].delete();
            q_last[i].delete();
            stall[i] = 1'b0;
        end
        busy_cnt = 0; busy_len = 10; pushed_bytes = 0;
        m_ptr = 0; m_owner = -1; m_next_owner = -1; m_cnt = 0;
        m_fin = 1'b0; m_expect_ovl = 1'b0; m_ovl_seen = 1'b0;
        ovl_count = 0;
        grant_log.delete(); sent_owner.delete(); sent_data.delete();
    endtask

    task automatic push_msg(input int r, input int len, input logic with_last);
        for (int b = 0; b < len; b++) begin
            q_data[r].push_back(PB'($urandom));
            q_last[r].push_back(with_last && (b == len - 1));
            pushed_bytes++;
        end
    endtask

    // One clock: drive at the falling edge, sample 1ns later, update models.
    task automatic step();
        logic en_ok;
        @(negedge clk);
        uart_tx_busy = (busy_cnt > 0);
        for (int i = 0; i < N; i++) begin
            if (q_data[i].size() > 0 && !stall[i]) begin
                req_valid[i]          = 1'b1;
                req_data[i*PB +: PB]  = q_data[i][0];
                req_last[i]           = q_last[i][0];
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*PB +: PB]  = PB'($urandom);
                req_last[i]           = 1'($urandom_range(0, 1));
            end
        end
        #1;
        if (resetn) begin
            if (m_next_owner >= 0) begin
                total++;
                if (grant !== onehot(m_next_owner)) begin
                    bad++;
                    $display("FAIL grant_start: grant=%b required=%b", grant, onehot(m_next_owner));
                end
                grant_log.push_back(m_next_owner);
                m_owner = m_next_owner; m_next_owner = -1; m_cnt = 0;
                m_fin = 1'b0; m_expect_ovl = 1'b0; m_ovl_seen = 1'b0;
            end else if (m_owner >= 0 && !m_fin) begin
                total++;
                if (grant !== onehot(m_owner)) begin
                    bad++;
                    $display("FAIL grant_hold: grant=%b required=%b", grant, onehot(m_owner));
                end
            end else if (m_owner >= 0) begin
                total++;
                if (grant === '0) begin
                    if (m_ovl_seen !== m_expect_ovl) begin
                        bad++;
                        $display("FAIL overlong_flag: seen=%b required=%b", m_ovl_seen, m_expect_ovl);
                    end
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                end else if (grant !== onehot(m_owner)) begin
                    bad++;
                    $display("FAIL grant_release: grant=%b required=%b or 0", grant, onehot(m_owner));
                end
            end else begin
                total++;
                if (grant !== '0) begin
                    bad++;
                    $display("FAIL grant_idle: grant=%b required=0", grant);
                end
            end
            if (m_owner < 0 && m_next_owner < 0 && grant === '0 && req_valid != '0)
                m_next_owner = rr_pick(req_valid, m_ptr);

            if (uart_tx_en === 1'b1) begin
                total++;
                en_ok = (m_owner >= 0) && !m_fin && req_valid[m_owner] && !uart_tx_busy;
                if (!en_ok) begin
                    bad++;
                    $display("FAIL en_unexpected: owner=%0d fin=%b busy=%b", m_owner, m_fin, uart_tx_busy);
                end else begin
                    total++;
                    if (req_ready !== onehot(m_owner)) begin
                        bad++;
                        $display("FAIL ready: req_ready=%b required=%b", req_ready, onehot(m_owner));
                    end
                    total++;
                    if (uart_tx_data !== q_data[m_owner][0]) begin
                        bad++;
                        $display("FAIL tx_data: data=%h required=%h", uart_tx_data, q_data[m_owner][0]);
                    end
                    sent_owner.push_back(m_owner);
                    sent_data.push_back(uart_tx_data);
                    m_cnt++;
                    if (q_last[m_owner][0] || m_cnt == MAXB) begin
                        m_fin        = 1'b1;
                        m_expect_ovl = !q_last[m_owner][0];
                    end
                    void'(q_data[m_owner].pop_front());
                    void'(q_last[m_owner].pop_front());
                end
            end else begin
                total++;
                if (req_ready !== '0) begin
                    bad++;
                    $display("FAIL ready_idle: req_ready=%b required=0", req_ready);
                end
            end

            if (err_overlong === 1'b1) begin
                total++;
                ovl_count++;
                if (!(m_owner >= 0 && m_fin && m_expect_ovl && !m_ovl_seen)) begin
                    bad++;
                    $display("FAIL overlong_pulse: owner=%0d fin=%b expected=%b", m_owner, m_fin, m_expect_ovl);
                end
                m_ovl_seen = 1'b1;
            end
        end
        if (uart_tx_en === 1'b1) busy_cnt = busy_len;
        else if (busy_cnt > 0) busy_cnt--;
    endtask

    task automatic run_until_idle(input int budget, input string name);
        int n = 0;
        while ((pending() || m_owner >= 0 || m_next_owner >= 0) && n < budget) begin
            step();
            n++;
        end
        total++;
        if (pending() || m_owner >= 0 || m_next_owner >= 0) begin
            bad++;
            $display("FAIL %s_timeout: still busy after %0d cycles", name, budget);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        resetn = 1'b0; req_valid = '0; req_data = '0; req_last = '0; uart_tx_busy = 1'b0;
        reset_model();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetn = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req_valid = N'($urandom); req_data = DW'($urandom);
            req_last  = N'($urandom); uart_tx_busy = 1'b0;
            #1;
            total++;
            if (grant !== '0 || req_ready !== '0) begin
                bad++;
                $display("FAIL reset_grant: grant=%b ready=%b required=0", grant, req_ready);
            end
            total++;
            if (uart_tx_en !== 1'b0 || uart_tx_data !== '0 || err_overlong !== 1'b0) begin
                bad++;
                $display("FAIL reset_tx: en=%b data=%h err=%b required=0", uart_tx_en, uart_tx_data, err_overlong);
            end
        end
        apply_reset();
    endtask

    task automatic test_single();
        apply_reset();
        q_data[2].push_back(8'h41); q_last[2].push_back(1'b0);
        q_data[2].push_back(8'h42); q_last[2].push_back(1'b1);
        run_until_idle(300, "single");
        total++;
        if (sent_data.size() != 2 || sent_data[0] !== 8'h41 || sent_data[1] !== 8'h42) begin
            bad++;
            $display("FAIL single_data: count=%0d first=%h second=%h required 41,42",
                     sent_data.size(), sent_data[0], sent_data[1]);
        end
        total++;
        if (grant_log.size() != 1 || grant_log[0] != 2 || grant !== '0) begin
            bad++;
            $display("FAIL single_grant: grants=%0d owner=%0d final=%b required one grant to 2, final 0",
                     grant_log.size(), grant_log[0], grant);
        end
        // Pointer is now 3: simultaneous requests from 0 and 3 serve 3 first.
        grant_log.delete();
        push_msg(0, 1, 1'b1);
        push_msg(3, 1, 1'b1);
        run_until_idle(300, "single_ptr");
        total++;
        if (grant_log.size() != 2 || grant_log[0] != 3 || grant_log[1] != 0) begin
            bad++;
            $display("FAIL single_ptr: order=%0d,%0d required 3,0", grant_log[0], grant_log[1]);
        end
    endtask

    task automatic test_contention();
        int   exp_o [6] = '{0, 0, 0, 3, 3, 3};
        logic ok;
        apply_reset();
        push_msg(0, 3, 1'b1);
        push_msg(3, 3, 1'b1);
        run_until_idle(600, "contention");
        ok = (sent_owner.size() == 6);
        for (int k = 0; k < 6 && ok; k++) ok = (sent_owner[k] == exp_o[k]);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL contention_order: bytes=%0d first=%0d fourth=%0d required 0,0,0,3,3,3",
                     sent_owner.size(), sent_owner[0], sent_owner[3]);
        end
    endtask

    task automatic test_fairness();
        logic ok;
        apply_reset();
        busy_len = 3;
        for (int rep = 0; rep < 2; rep++)
            for (int r = 0; r < N; r++) push_msg(r, 1, 1'b1);
        run_until_idle(600, "fairness");
        ok = (grant_log.size() == 8);
        for (int k = 0; k < 8 && ok; k++) ok = (grant_log[k] == (k % N));
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL fairness_order: grants=%0d g0=%0d g1=%0d g4=%0d required 0,1,2,3,0,1,2,3",
                     grant_log.size(), grant_log[0], grant_log[1], grant_log[4]);
        end
    endtask

    task automatic test_overlong();
        apply_reset();
        push_msg(1, MAXB, 1'b0);
        push_msg(2, 1, 1'b1);
        run_until_idle(400, "overlong");
        total++;
        if (ovl_count != 1) begin
            bad++;
            $display("FAIL overlong_count: pulses=%0d required 1", ovl_count);
        end
        total++;
        if (sent_owner.size() != 5 || sent_owner[3] != 1 || sent_owner[4] != 2 ||
            grant_log.size() != 2 || grant_log[1] != 2) begin
            bad++;
            $display("FAIL overlong_handoff: bytes=%0d grants=%0d next=%0d required 5 bytes, grants 1 then 2",
                     sent_owner.size(), grant_log.size(), grant_log[1]);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int round = 0; round < 4; round++) begin
            busy_len = $urandom_range(1, 12);
            for (int burst = 0; burst < 2; burst++) begin
                for (int r = 0; r < N; r++) begin
                    int nmsg = $urandom_range(0, 2);
                    for (int m = 0; m < nmsg; m++) begin
                        if ($urandom_range(0, 9) == 0) push_msg(r, MAXB, 1'b0);
                        else push_msg(r, $urandom_range(1, MAXB), 1'b1);
                    end
                end
                for (int c = 0; c < int'($urandom_range(0, 30)); c++) step();
            end
            run_until_idle(4000, "random");
        end
        total++;
        if (sent_data.size() != pushed_bytes) begin
            bad++;
            $display("FAIL random_bytes: sent=%0d required=%0d", sent_data.size(), pushed_bytes);
        end
    endtask

    task automatic test_stall_reset();
        int n;
        int en_seen;
        apply_reset();
        push_msg(0, 3, 1'b1);
        n = 0;
        while (sent_data.size() < 1 && n < 100) begin step(); n++; end
        total++;
        if (sent_data.size() != 1) begin
            bad++;
            $display("FAIL stall_first: bytes=%0d required 1", sent_data.size());
        end
        stall[0] = 1'b1;
        en_seen = 0;
        for (int c = 0; c < 65; c++) begin
            step();
            if (uart_tx_en === 1'b1) en_seen++;
        end
        total++;
        if (en_seen != 0) begin
            bad++;
            $display("FAIL stall_quiet: strobes=%0d required 0", en_seen);
        end
        // Requester recovers exactly as reset hits: no byte may leave.
        @(negedge clk);
        resetn = 1'b0; uart_tx_busy = 1'b0;
        req_valid = 4'b0001; req_data[PB-1:0] = q_data[0][0]; req_last[0] = 1'b0;
        #1;
        total++;
        if (uart_tx_en !== 1'b0 || req_ready !== '0) begin
            bad++;
            $display("FAIL stall_reset_cycle: en=%b ready=%b required 0", uart_tx_en, req_ready);
        end
        @(negedge clk);
        resetn = 1'b1; req_valid = '0; req_last = '0;
        #1;
        total++;
        if (grant !== '0 || req_ready !== '0 || uart_tx_en !== 1'b0 ||
            uart_tx_data !== '0 || err_overlong !== 1'b0) begin
            bad++;
            $display("FAIL stall_reset_out: grant=%b ready=%b en=%b data=%h err=%b required all 0",
                     grant, req_ready, uart_tx_en, uart_tx_data, err_overlong);
        end
        reset_model();
        push_msg(3, 1, 1'b1);
        push_msg(1, 2, 1'b1);
        run_until_idle(400, "post_reset");
        total++;
        if (grant_log.size() != 2 || grant_log[0] != 1 || grant_log[1] != 3) begin
            bad++;
            $display("FAIL post_reset_order: order=%0d,%0d required 1,3", grant_log[0], grant_log[1]);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; req_valid = '0; req_data = '0; req_last = '0; uart_tx_busy = 1'b0;
        reset_model();
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_overlong();
        test_random();
        test_stall_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of message requesters sharing one UART transmitter (2..8).
REQ-002 Parameter PAYLOAD_BITS, default 8: byte width; matches the transmitter payload width.
REQ-003 Parameter MAX_MSG_BYTES, default 32: longest message before forced release.
REQ-004 clk  in  1  system clock; all logic rising-edge.
REQ-005 resetn  in  1  reset, synchronous, active-low.
REQ-006 req_valid  in  N_REQ  per-requester byte valid.
REQ-007 req_data  in  N_REQ*PAYLOAD_BITS  packed bytes; requester i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
REQ-008 req_last  in  N_REQ  per-requester last-byte-of-message flag, qualified by req_valid.
REQ-009 req_ready  out  N_REQ  one-cycle byte-accept pulse to the granted requester.
REQ-010 grant  out  N_REQ  one-hot owner of the transmitter; all-zero when idle.
REQ-011 uart_tx_en  out  1  one-cycle send strobe to the transmitter.
REQ-012 uart_tx_data  out  PAYLOAD_BITS  byte to the transmitter, stable while uart_tx_en=1.
REQ-013 uart_tx_busy  in  1  transmitter busy; rises the cycle after an accepted uart_tx_en and falls when the stop bit ends.
REQ-014 err_overlong  out  1  one-cycle pulse when a message is force-terminated at MAX_MSG_BYTES.

Function
REQ-015 The FSM SHALL have states IDLE, SEND, WAIT, and NEXT.
REQ-016 IDLE: when any req_valid=1, the block SHALL select the requester by round-robin starting at rr_ptr, set grant, and enter SEND on the next cycle; otherwise it SHALL stay in IDLE with grant=0.
REQ-017 SEND: when uart_tx_busy=0 and req_valid[g]=1, the block SHALL assert uart_tx_en=1, drive uart_tx_data=req_data[g], pulse req_ready[g]=1 in the same cycle, and go to WAIT; otherwise it SHALL hold in SEND with uart_tx_en=0.
REQ-018 WAIT: the block SHALL hold until uart_tx_busy=0, with the first WAIT cycle ignored (busy-rise guard), then go to NEXT.
REQ-019 NEXT: if the sent byte had req_last=1 or byte_cnt reached MAX_MSG_BYTES, the block SHALL set rr_ptr=(g+1) mod N_REQ, clear grant, and go to IDLE; otherwise it SHALL return to SEND.
REQ-020 Grant SHALL be held for a whole message; other requesters are never interleaved mid-message.
REQ-021 byte_cnt SHALL be $clog2(MAX_MSG_BYTES+1) bits, cleared on grant, and incremented on each uart_tx_en.
REQ-022 A release by byte_cnt==MAX_MSG_BYTES without req_last SHALL pulse err_overlong for one cycle in NEXT.
REQ-023 A requester whose req_valid drops mid-message SHALL keep grant; the block SHALL wait indefinitely in SEND.
REQ-024 Simultaneous requests SHALL be resolved lowest index at or after rr_ptr first, wrapping N_REQ-1 to 0.
REQ-025 req_last and req_data SHALL be sampled only in the uart_tx_en cycle; the last flag SHALL be registered for NEXT.
REQ-026 Minimum spacing SHALL be one uart_tx_en per transmitter frame; at most one req_ready bit is high in any cycle.

Reset
REQ-027 On resetn=0 at a clk edge: state=IDLE, rr_ptr=0, grant=0, req_ready=0, uart_tx_en=0, uart_tx_data=0, byte_cnt=0, err_overlong=0.
REQ-028 Reset mid-message SHALL abandon the message without any further uart_tx_en; an in-flight transmitter frame is not the block's concern.

Structure
REQ-029 The FSM state encodings and a PAYLOAD_BITS default constant SHALL live in a shared package, uart_pkg.
REQ-030 The round-robin selector SHALL be one sub-module, rr_select (inputs: request vector and pointer; output: one-hot pick, combinational).
REQ-031 The block SHALL contain no byte buffering beyond the registered last flag; requesters hold data until req_ready.

Verification
REQ-032 Single message: requester 2 sends 0x41,0x42 (last on 0x42) against a 10-cycle busy model -> two uart_tx_en pulses with data 0x41 then 0x42; grant=4'b0100 throughout; grant returns to 0; rr_ptr=3.
REQ-033 Contention: requesters 0 and 3 each send 3-byte messages with rr_ptr=0 -> all of requester 0's bytes are sent before requester 3's, with no interleave.
REQ-034 Fairness: all 4 requesters send 1-byte messages continuously for 8 messages -> grant order is 0,1,2,3,0,1,2,3.
REQ-035 Overlong: MAX_MSG_BYTES=4 and requester 1 never asserts last -> 4 bytes are sent, err_overlong pulses once, and grant moves to the next requester.
REQ-036 Stall and reset: requester 0 drops req_valid after byte 1 -> no uart_tx_en for 50 cycles; then resetn=0 for 1 cycle -> all outputs are zero and state is IDLE next cycle.
